// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle MIPS control sequencer: steps each instruction through IF/ID/EX/MEM/WB.
// Optional MEM wait states on MemReady are enabled by defining MC_CTRL_WAIT_EN.
//
//   state | meaning
//   ------+-----------------------------------------------
//   IF    | fetch: load IR, PC <= PC+4
//   ID    | decode; j completes here, illegal pulses here
//   EX    | ALU operation; beq completes here
//   MEM   | data-memory read (lw) or write (sw)
//   WB    | register-file write back
module mc_ctrl_fsm (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    input  logic        Zero,
    input  logic        MemReady,
    output logic        PCWr,
    output logic [1:0]  PCSrc,
    output logic        IRWr,
    output logic        RegWr,
    output logic        RegDst,
    output logic        MemtoReg,
    output logic        ExtOp,
    output logic        ALUSrc,
    output logic [2:0]  ALUctr,
    output logic        MemRd,
    output logic        MemWr,
    output logic        Illegal,
    output logic        InstrDone,
    output logic [2:0]  State,
    output logic [31:0] InstrCnt
);

    typedef enum logic [2:0] {
        S_IF  = 3'd0,
        S_ID  = 3'd1,
        S_EX  = 3'd2,
        S_MEM = 3'd3,
        S_WB  = 3'd4
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUBU  = 6'b100011;
    localparam logic [5:0] FN_SLT   = 6'b101010;

    localparam logic [2:0] ALU_ADDU = 3'b000;
    localparam logic [2:0] ALU_SUBU = 3'b001;
    localparam logic [2:0] ALU_OR   = 3'b010;
    localparam logic [2:0] ALU_SLT  = 3'b011;
    localparam logic [2:0] ALU_LUI  = 3'b100;

    state_t      state, state_nxt;
    logic        is_rtype, is_ori, is_lui, is_lw, is_sw, is_beq, is_j, is_legal;
    logic [2:0]  alu_r;
    logic [2:0]  ex_alu_ctr;
    logic        ex_alu_src;
    logic        mem_go;

    always_comb begin
        is_rtype = 1'b0;
        alu_r    = ALU_ADDU;
        if (opcode == OP_RTYPE) begin
            case (funct)
                FN_ADDU: begin is_rtype = 1'b1; alu_r = ALU_ADDU; end
                FN_SUBU: begin is_rtype = 1'b1; alu_r = ALU_SUBU; end
                FN_SLT:  begin is_rtype = 1'b1; alu_r = ALU_SLT;  end
                default: begin is_rtype = 1'b0; alu_r = ALU_ADDU; end
            endcase
        end
    end

    assign is_ori   = (opcode == OP_ORI);
    assign is_lui   = (opcode == OP_LUI);
    assign is_lw    = (opcode == OP_LW);
    assign is_sw    = (opcode == OP_SW);
    assign is_beq   = (opcode == OP_BEQ);
    assign is_j     = (opcode == OP_J);
    assign is_legal = is_rtype | is_ori | is_lui | is_lw | is_sw | is_beq | is_j;

    // ALU setup is shared by EX and WB so ALUOut's inputs stay put during write back.
    always_comb begin
        ex_alu_ctr = ALU_ADDU;
        ex_alu_src = 1'b0;
        if (is_rtype) begin
            ex_alu_ctr = alu_r;
            ex_alu_src = 1'b0;
        end else if (is_ori) begin
            ex_alu_ctr = ALU_OR;
            ex_alu_src = 1'b1;
        end else if (is_lui) begin
            ex_alu_ctr = ALU_LUI;
            ex_alu_src = 1'b1;
        end else if (is_lw || is_sw) begin
            ex_alu_ctr = ALU_ADDU;
            ex_alu_src = 1'b1;
        end else if (is_beq) begin
            ex_alu_ctr = ALU_SUBU;
            ex_alu_src = 1'b0;
        end
    end

`ifdef MC_CTRL_WAIT_EN
    assign mem_go = MemReady;
`else
    logic unused_mem_ready;
    assign unused_mem_ready = MemReady;
    assign mem_go           = 1'b1;
`endif

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= S_IF;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            InstrCnt <= 32'd0;
        end else if (InstrDone) begin
            InstrCnt <= InstrCnt + 32'd1;
        end
    end

    always_comb begin
        state_nxt = S_IF;
        case (state)
            S_IF:  state_nxt = S_ID;
            S_ID:  state_nxt = (is_j || !is_legal) ? S_IF : S_EX;
            S_EX: begin
                if (is_lw || is_sw) state_nxt = S_MEM;
                else if (is_beq)    state_nxt = S_IF;
                else                state_nxt = S_WB;
            end
            S_MEM: begin
                if (!mem_go)    state_nxt = S_MEM;
                else if (is_lw) state_nxt = S_WB;
                else            state_nxt = S_IF;
            end
            S_WB:    state_nxt = S_IF;
            default: state_nxt = S_IF;
        endcase
    end

    always_comb begin
        PCWr      = 1'b0;
        PCSrc     = 2'b00;
        IRWr      = 1'b0;
        RegWr     = 1'b0;
        RegDst    = 1'b0;
        MemtoReg  = 1'b0;
        ExtOp     = 1'b0;
        ALUSrc    = 1'b0;
        ALUctr    = 3'b000;
        MemRd     = 1'b0;
        MemWr     = 1'b0;
        Illegal   = 1'b0;
        InstrDone = 1'b0;
        case (state)
            S_IF: begin
                IRWr = 1'b1;
                PCWr = 1'b1;
            end
            S_ID: begin
                if (!is_legal) begin
                    Illegal = 1'b1;
                end else if (is_j) begin
                    PCWr      = 1'b1;
                    PCSrc     = 2'b10;
                    InstrDone = 1'b1;
                end
            end
            S_EX: begin
                ALUctr = ex_alu_ctr;
                ALUSrc = ex_alu_src;
                ExtOp  = is_lw | is_sw | is_beq;
                if (is_beq) begin
                    PCSrc     = 2'b01;
                    PCWr      = Zero;
                    InstrDone = 1'b1;
                end
            end
            S_MEM: begin
                MemRd     = is_lw;
                MemWr     = is_sw;
                InstrDone = is_sw & mem_go;
            end
            S_WB: begin
                RegWr     = 1'b1;
                InstrDone = 1'b1;
                MemtoReg  = is_lw;
                RegDst    = is_rtype;
                ALUctr    = ex_alu_ctr;
                ALUSrc    = ex_alu_src;
            end
            default: ;
        endcase
        // Reset kills every strobe at once so an aborted instruction leaves no partial write.
        if (Reset) begin
            PCWr      = 1'b0;
            IRWr      = 1'b0;
            RegWr     = 1'b0;
            MemRd     = 1'b0;
            MemWr     = 1'b0;
            Illegal   = 1'b0;
            InstrDone = 1'b0;
        end
    end

    assign State = state;

endmodule
